// File: rtl/apb_i2c_regif.sv
// rtl/apb_i2c_regif.sv - APB register file and FIFO front-end for the I2C core
module apb_i2c_regif #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int CFG_W    = 14,
    parameter int TMO_W    = 14,
    parameter int WAIT_MAX = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              TX_FULL,
    input  logic              TX_EMPTY,
    input  logic              RX_EMPTY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              I2C_ERROR,
    output logic              WR_ENA,
    output logic              RD_ENA,
    output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
    output logic [CFG_W-1:0]  REG_CONFIG,
    output logic [TMO_W-1:0]  REG_TIMEOUT,
    output logic              INT
);

    localparam int CNT_W = $clog2(WAIT_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [ADDR_W-1:0] A_TXDATA  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_RXDATA  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_CONFIG  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_INT_EN  = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_INT_PND = ADDR_W'(8'h18);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CFG_W-1:0] config_q, config_d;
    logic [TMO_W-1:0] timeout_q, timeout_d;
    logic [3:0]       int_en_q, int_en_d;
    logic [3:0]       int_pend_q, int_pend_d;
    logic             tmo_seen_q, tmo_seen_d;
    logic             int_q, int_d;
    logic             tx_empty_prev_q, tx_empty_prev_d;
    logic             rx_empty_prev_q, rx_empty_prev_d;
    logic             i2c_err_prev_q, i2c_err_prev_d;

    logic in_access, sel_tx, sel_rx, sel_cfg, sel_tmo, sel_sts, sel_ien, sel_ipd;
    logic mapped, tx_push, rx_pop, blocked, wait_hit, bad_access, reg_wr, timeout_evt;
    logic [3:0] int_set, int_clr;

    assign WRITE_DATA_ON_TX = PWDATA;
    assign REG_CONFIG       = config_q;
    assign REG_TIMEOUT      = timeout_q;
    assign INT              = int_q;

    // Address decode and the combinational APB response; everything is gated off outside ACCESS and in reset
    always_comb begin
        in_access   = (state_q == ACCESS) && PSEL && !PRESET;
        sel_tx      = (PADDR == A_TXDATA);
        sel_rx      = (PADDR == A_RXDATA);
        sel_cfg     = (PADDR == A_CONFIG);
        sel_tmo     = (PADDR == A_TIMEOUT);
        sel_sts     = (PADDR == A_STATUS);
        sel_ien     = (PADDR == A_INT_EN);
        sel_ipd     = (PADDR == A_INT_PND);
        mapped      = sel_tx | sel_rx | sel_cfg | sel_tmo | sel_sts | sel_ien | sel_ipd;
        tx_push     = sel_tx && PWRITE;
        rx_pop      = sel_rx && !PWRITE;
        blocked     = (tx_push && TX_FULL) || (rx_pop && RX_EMPTY);
        wait_hit    = blocked && (wait_cnt_q == CNT_W'(WAIT_MAX - 1));
        bad_access  = !mapped || (sel_tx && !PWRITE) || (sel_rx && PWRITE) || (sel_sts && PWRITE);
        PREADY      = in_access && (!blocked || wait_hit);
        PSLVERR     = in_access && (bad_access || wait_hit);
        WR_ENA      = in_access && tx_push && !TX_FULL;
        RD_ENA      = in_access && rx_pop && !RX_EMPTY;
        reg_wr      = in_access && PWRITE && !bad_access;
        timeout_evt = in_access && wait_hit;
    end

    // Read data mux; error completions and writes return zero
    always_comb begin
        PRDATA = '0;
        if (in_access && !PWRITE && !wait_hit) begin
            if (sel_rx)  PRDATA = RX_DATA;
            if (sel_cfg) PRDATA = DATA_W'(config_q);
            if (sel_tmo) PRDATA = DATA_W'(timeout_q);
            if (sel_sts) PRDATA = DATA_W'({tmo_seen_q, I2C_ERROR, RX_EMPTY, TX_FULL, TX_EMPTY});
            if (sel_ien) PRDATA = DATA_W'(int_en_q);
            if (sel_ipd) PRDATA = DATA_W'(int_pend_q);
        end
    end

    // Bus FSM and wait counter; the counter restarts on every entry to ACCESS
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    state_d    = ACCESS;
                    wait_cnt_d = '0;
                end
            end
            ACCESS: begin
                if (!PSEL || PREADY) state_d = IDLE;
                else                 wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Register writes and interrupt bookkeeping; a new event outranks a same-cycle write-1-to-clear
    always_comb begin
        config_d        = config_q;
        timeout_d       = timeout_q;
        int_en_d        = int_en_q;
        if (reg_wr && sel_cfg) config_d  = PWDATA[CFG_W-1:0];
        if (reg_wr && sel_tmo) timeout_d = PWDATA[TMO_W-1:0];
        if (reg_wr && sel_ien) int_en_d  = PWDATA[3:0];
        int_set         = {timeout_evt,
                           I2C_ERROR && !i2c_err_prev_q,
                           rx_empty_prev_q && !RX_EMPTY,
                           TX_EMPTY && !tx_empty_prev_q};
        int_clr         = (reg_wr && sel_ipd) ? PWDATA[3:0] : 4'b0000;
        int_pend_d      = (int_pend_q & ~int_clr) | int_set;
        tmo_seen_d      = tmo_seen_q || timeout_evt;
        int_d           = |(int_pend_q & int_en_q);
        tx_empty_prev_d = TX_EMPTY;
        rx_empty_prev_d = RX_EMPTY;
        i2c_err_prev_d  = I2C_ERROR;
    end

    // State registers; edge-detect history resets to the idle FIFO/core levels
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q         <= IDLE;
            wait_cnt_q      <= '0;
            config_q        <= '0;
            timeout_q       <= '0;
            int_en_q        <= '0;
            int_pend_q      <= '0;
            tmo_seen_q      <= 1'b0;
            int_q           <= 1'b0;
            tx_empty_prev_q <= 1'b1;
            rx_empty_prev_q <= 1'b1;
            i2c_err_prev_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            config_q        <= config_d;
            timeout_q       <= timeout_d;
            int_en_q        <= int_en_d;
            int_pend_q      <= int_pend_d;
            tmo_seen_q      <= tmo_seen_d;
            int_q           <= int_d;
            tx_empty_prev_q <= tx_empty_prev_d;
            rx_empty_prev_q <= rx_empty_prev_d;
            i2c_err_prev_q  <= i2c_err_prev_d;
        end
    end

endmodule

// File: tb/tb_apb_i2c_regif.sv
// tb/tb_apb_i2c_regif.sv - self-checking bench for apb_i2c_regif
module tb_apb_i2c_regif;

    localparam int WAIT_MAX = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        TX_FULL = 1'b0;
    logic        TX_EMPTY = 1'b1;
    logic        RX_EMPTY = 1'b1;
    logic [31:0] RX_DATA = 32'h0;
    logic        I2C_ERROR = 1'b0;
    logic        WR_ENA;
    logic        RD_ENA;
    logic [31:0] WRITE_DATA_ON_TX;
    logic [13:0] REG_CONFIG;
    logic [13:0] REG_TIMEOUT;
    logic        INT;

    apb_i2c_regif dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY), .RX_EMPTY(RX_EMPTY), .RX_DATA(RX_DATA),
        .I2C_ERROR(I2C_ERROR), .WR_ENA(WR_ENA), .RD_ENA(RD_ENA),
        .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX), .REG_CONFIG(REG_CONFIG),
        .REG_TIMEOUT(REG_TIMEOUT), .INT(INT)
    );

    always #5 PCLK = ~PCLK;

    // reference model state
    logic [13:0] cfg_m, tmo_m;
    logic [3:0]  en_m, pend_m;
    bit          seen_m, tx_prev_m, rx_prev_m, err_prev_m;
    bit          rise_in_access = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_tx_empty(input logic v);
        if (v && !tx_prev_m) pend_m[0] = 1'b1;
        tx_prev_m = v;
        TX_EMPTY  = v;
    endtask

    task automatic drive_rx_empty(input logic v);
        if (!v && rx_prev_m) pend_m[1] = 1'b1;
        rx_prev_m = v;
        RX_EMPTY  = v;
    endtask

    task automatic drive_err(input logic v);
        if (v && !err_prev_m) pend_m[2] = 1'b1;
        err_prev_m = v;
        I2C_ERROR  = v;
    endtask

    task automatic model_reset();
        cfg_m = '0; tmo_m = '0; en_m = '0; pend_m = '0; seen_m = 1'b0;
        tx_prev_m = 1'b1; rx_prev_m = 1'b1; err_prev_m = 1'b0;
    endtask

    // One APB transfer; nblk = number of ACCESS cycles the addressed FIFO stays blocked
    task automatic apb(input logic [7:0] addr, input bit wr, input logic [31:0] wdata,
                       input int nblk, input logic [31:0] rxd,
                       output logic [31:0] rdata, output bit err, output int lat,
                       output int stb, output logic [31:0] wdtx);
        bit done, tx, rx;
        tx = (addr == 8'h00) && wr;
        rx = (addr == 8'h04) && !wr;
        stb = 0; rdata = '0; err = 1'b0; wdtx = '0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata; RX_DATA = rxd;
        if (tx) TX_FULL = (nblk > 0);
        if (rx) drive_rx_empty(nblk > 0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        lat = 0; done = 1'b0;
        while (!done) begin
            lat++;
            if (tx) TX_FULL = (lat <= nblk);
            if (rx) drive_rx_empty(lat <= nblk);
            if (lat == 1 && rise_in_access) drive_err(1'b1);
            #1;
            stb += int'(WR_ENA) + int'(RD_ENA);
            if (PREADY) begin
                done = 1'b1; rdata = PRDATA; err = PSLVERR; wdtx = WRITE_DATA_ON_TX;
            end else if (lat >= 64) begin
                check("pready_bound", PREADY, 1);
                done = 1'b1;
            end else begin
                @(posedge PCLK); #1;
            end
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; TX_FULL = 1'b0;
    endtask

    // Transfer plus comparison against the reference model
    task automatic do_xfer(input logic [7:0] addr, input bit wr, input logic [31:0] wdata,
                           input int nblk, output logic [31:0] rdata, output bit err, output int lat);
        logic [31:0] rxd, wdtx, exp_rd;
        int stb, elat, estb;
        bit mapped, tx, rx, bad, eerr, tmo;
        rxd = $urandom;
        apb(addr, wr, wdata, nblk, rxd, rdata, err, lat, stb, wdtx);
        mapped = addr inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        tx  = (addr == 8'h00) && wr;
        rx  = (addr == 8'h04) && !wr;
        bad = !mapped || (addr == 8'h00 && !wr) || (addr == 8'h04 && wr) || (addr == 8'h10 && wr);
        if (tx || rx) begin
            tmo  = (nblk >= WAIT_MAX);
            elat = tmo ? WAIT_MAX : nblk + 1;
            eerr = tmo;
            estb = tmo ? 0 : 1;
            if (tmo) begin pend_m[3] = 1'b1; seen_m = 1'b1; end
        end else begin
            elat = 1; eerr = bad; estb = 0;
        end
        check($sformatf("latency@%02h", addr), lat, elat);
        check($sformatf("pslverr@%02h", addr), err, eerr);
        check($sformatf("strobes@%02h", addr), stb, estb);
        if (tx) check("tx_data", wdtx, wdata);
        if (!wr) begin
            case (addr)
                8'h04:   exp_rd = rxd;
                8'h08:   exp_rd = {18'b0, cfg_m};
                8'h0C:   exp_rd = {18'b0, tmo_m};
                8'h10:   exp_rd = {27'b0, seen_m, I2C_ERROR, RX_EMPTY, 1'b0, TX_EMPTY};
                8'h14:   exp_rd = {28'b0, en_m};
                8'h18:   exp_rd = {28'b0, pend_m};
                default: exp_rd = '0;
            endcase
            if (!eerr || bad) check($sformatf("prdata@%02h", addr), rdata, exp_rd);
        end
        if (wr && !bad) begin
            case (addr)
                8'h08:   cfg_m = wdata[13:0];
                8'h0C:   tmo_m = wdata[13:0];
                8'h14:   en_m = wdata[3:0];
                8'h18:   pend_m = pend_m & ~wdata[3:0];
                default: ;
            endcase
        end
        check("reg_config", REG_CONFIG, cfg_m);
        check("reg_timeout", REG_TIMEOUT, tmo_m);
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lt;
        logic [7:0] addrs [9];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'hFC};

        model_reset();
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", PREADY, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_wr_ena", WR_ENA, 0);
        check("rst_rd_ena", RD_ENA, 0);
        check("rst_int", INT, 0);
        check("rst_config", REG_CONFIG, 0);
        check("rst_timeout", REG_TIMEOUT, 0);
        PRESET = 1'b0;

        // configuration register round trip
        do_xfer(8'h08, 1'b1, 32'hFFFF_FFFF, 0, rd, er, lt);
        do_xfer(8'h08, 1'b0, 32'h0, 0, rd, er, lt);
        check("t1_config", rd, 32'h0000_3FFF);

        // TX push stalled for three cycles
        do_xfer(8'h00, 1'b1, 32'h0000_00A5, 3, rd, er, lt);
        check("t2_latency", lt, 4);

        // RX pop that never gets data
        do_xfer(8'h04, 1'b0, 32'h0, 100, rd, er, lt);
        check("t3_latency", lt, WAIT_MAX);
        check("t3_pslverr", er, 1);
        do_xfer(8'h10, 1'b0, 32'h0, 0, rd, er, lt);
        check("t3_status4", rd[4], 1);
        do_xfer(8'h18, 1'b0, 32'h0, 0, rd, er, lt);
        check("t3_pend", rd, 32'h8);
        do_xfer(8'h18, 1'b1, 32'hF, 0, rd, er, lt);

        // I2C error interrupt, clear, and set-beats-clear
        do_xfer(8'h14, 1'b1, 32'h4, 0, rd, er, lt);
        drive_err(1'b1);
        @(posedge PCLK); #1;
        check("t4_int_latency", INT, 0);
        @(posedge PCLK); #1;
        check("t4_int_set", INT, 1);
        drive_err(1'b0);
        do_xfer(8'h18, 1'b0, 32'h0, 0, rd, er, lt);
        check("t4_pend", rd, 32'h4);
        do_xfer(8'h18, 1'b1, 32'h4, 0, rd, er, lt);
        check("t4_int_hold", INT, 1);
        @(posedge PCLK); #1;
        check("t4_int_fall", INT, 0);
        do_xfer(8'h18, 1'b0, 32'h0, 0, rd, er, lt);
        check("t4_pend_clr", rd, 32'h0);
        drive_err(1'b1);
        repeat (2) @(posedge PCLK);
        #1;
        drive_err(1'b0);
        rise_in_access = 1'b1;
        do_xfer(8'h18, 1'b1, 32'h4, 0, rd, er, lt);
        rise_in_access = 1'b0;
        pend_m[2] = 1'b1;
        do_xfer(8'h18, 1'b0, 32'h0, 0, rd, er, lt);
        check("t4_set_wins", rd, 32'h4);
        drive_err(1'b0);
        do_xfer(8'h18, 1'b1, 32'hF, 0, rd, er, lt);

        // error responses leave registers alone
        do_xfer(8'h0C, 1'b1, 32'h1234_5ABC, 0, rd, er, lt);
        do_xfer(8'h1C, 1'b0, 32'h0, 0, rd, er, lt);
        check("t5_unmapped", er, 1);
        do_xfer(8'h10, 1'b1, 32'hFFFF_FFFF, 0, rd, er, lt);
        check("t5_status_wr", er, 1);
        do_xfer(8'h08, 1'b0, 32'h0, 0, rd, er, lt);
        do_xfer(8'h0C, 1'b0, 32'h0, 0, rd, er, lt);
        check("t5_timeout", rd, 32'h1ABC);
        do_xfer(8'h14, 1'b0, 32'h0, 0, rd, er, lt);

        // reset in the middle of a stalled TX push
        do_xfer(8'h08, 1'b1, 32'h155, 0, rd, er, lt);
        do_xfer(8'h14, 1'b1, 32'hF, 0, rd, er, lt);
        drive_tx_empty(1'b0);
        @(posedge PCLK); #1;
        drive_tx_empty(1'b1);
        repeat (2) @(posedge PCLK);
        #1;
        check("t6_int_before", INT, |(pend_m & en_m));
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'h5A; TX_FULL = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (4) begin
            @(posedge PCLK); #1;
            check("t6_wait_pready", PREADY, 0);
        end
        PRESET = 1'b1;
        TX_FULL = 1'b0;
        #1;
        check("t6_rst_wr_ena", WR_ENA, 0);
        check("t6_rst_pready", PREADY, 0);
        @(posedge PCLK); #1;
        check("t6_rst_wr_ena2", WR_ENA, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_reset();
        drive_tx_empty(TX_EMPTY);
        drive_rx_empty(RX_EMPTY);
        drive_err(I2C_ERROR);
        check("t6_config", REG_CONFIG, 0);
        check("t6_timeout", REG_TIMEOUT, 0);
        check("t6_int", INT, 0);
        do_xfer(8'h08, 1'b0, 32'h0, 0, rd, er, lt);
        do_xfer(8'h0C, 1'b0, 32'h0, 0, rd, er, lt);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            bit w;
            int nb;
            a  = addrs[$urandom_range(0, 8)];
            w  = bit'($urandom_range(0, 1));
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            do_xfer(a, w, $urandom, nb, rd, er, lt);
            if ($urandom_range(0, 3) == 0) drive_tx_empty(!TX_EMPTY);
            if ($urandom_range(0, 3) == 0) drive_err(!I2C_ERROR);
            repeat (2) @(posedge PCLK);
            #1;
            check("rnd_int", INT, |(pend_m & en_m));
            check("rnd_idle_pready", PREADY, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_i2c_regif.md
Name: apb_i2c_regif

Overview:
- Parametrised APB slave register file and FIFO front-end for the I2C core.
- Replaces the fixed zero-wait bridge with FIFO-aware wait states, a wait-state timeout that returns PSLVERR, and readable status.
- Adds a maskable, sticky, write-1-to-clear interrupt controller that drives a single interrupt line.
- Sits between the APB interconnect and the I2C core's TX/RX FIFOs and configuration inputs.

Parameters:
DATA_W, 32, APB data width and FIFO data width (must be at least 16).
ADDR_W, 8, number of decoded PADDR bits; upper address bits are ignored.
CFG_W, 14, width of the CONFIG register.
TMO_W, 14, width of the TIMEOUT register.
WAIT_MAX, 16, maximum number of wait cycles before a stalled FIFO access completes with an error (must be at least 2).

Ports:
PCLK  in  1  clock; every register updates on the rising edge
PRESET  in  1  synchronous reset, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response; valid only while PREADY=1
TX_FULL  in  1  TX FIFO full
TX_EMPTY  in  1  TX FIFO empty
RX_EMPTY  in  1  RX FIFO empty
RX_DATA  in  DATA_W  RX FIFO head data (first-word fall-through)
I2C_ERROR  in  1  error flag from the I2C core
WR_ENA  out  1  TX FIFO push strobe
RD_ENA  out  1  RX FIFO pop strobe
WRITE_DATA_ON_TX  out  DATA_W  TX FIFO push data; always equal to PWDATA
REG_CONFIG  out  CFG_W  configuration to the I2C core
REG_TIMEOUT  out  TMO_W  timeout value to the I2C core
INT  out  1  registered interrupt output

Behaviour:
- Register map (byte offsets):
  - 0x00 TXDATA: write-only.
  - 0x04 RXDATA: read-only.
  - 0x08 CONFIG: read/write.
  - 0x0C TIMEOUT: read/write.
  - 0x10 STATUS: read-only; bits [4:0] = {wait_timeout_seen, I2C_ERROR, RX_EMPTY, TX_FULL, TX_EMPTY}.
  - 0x14 INT_EN: read/write, 4 bits.
  - 0x18 INT_PEND: read; write-1-to-clear, 4 bits.
  - Unused read bits return 0.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on PSEL=1, PENABLE=0.
  - SETUP -> ACCESS on PSEL=1, PENABLE=1.
  - ACCESS -> IDLE in the cycle PREADY=1.
  - PSEL=0 in SETUP or ACCESS -> IDLE, with no side effects.
- PREADY, PSLVERR, PRDATA, WR_ENA and RD_ENA are combinational from state and inputs. They are 0 outside ACCESS, and 0 while PRESET=1.
- Register accesses (CONFIG, TIMEOUT, STATUS, INT_EN, INT_PEND) complete zero-wait: PREADY=1 in the first ACCESS cycle.
  - Register writes take effect on that edge.
  - CONFIG and TIMEOUT keep PWDATA[CFG_W-1:0] / PWDATA[TMO_W-1:0].
- TXDATA write:
  - TX_FULL=0: PREADY=1 and a single WR_ENA pulse in that cycle.
  - TX_FULL=1: PREADY=0 and the wait counter increments each cycle.
- RXDATA read:
  - RX_EMPTY=0: PREADY=1, PRDATA=RX_DATA and a single RD_ENA pulse in that cycle.
  - RX_EMPTY=1: wait, as for TXDATA.
- Wait counter:
  - Cleared on entry to ACCESS.
  - When it reaches WAIT_MAX-1 and the FIFO is still blocked, the cycle completes with PREADY=1 and PSLVERR=1.
  - No WR_ENA/RD_ENA is issued on that completion.
  - wait_timeout_seen and INT_PEND[3] are set.
  - Total ACCESS length is therefore at most WAIT_MAX cycles.
- PSLVERR=1 with zero-wait and no side effects for:
  - unmapped offsets;
  - a read of TXDATA (PRDATA=0);
  - a write to RXDATA or STATUS.
- INT_PEND set sources:
  - [0] TX_EMPTY rising edge.
  - [1] RX_EMPTY falling edge (data arrived).
  - [2] I2C_ERROR rising edge.
  - [3] wait timeout.
  - Edges are detected against registered previous values; after reset those are TX_EMPTY=1, RX_EMPTY=1, I2C_ERROR=0, so no spurious events occur.
- Set and W1C of the same INT_PEND bit on the same edge: set wins.
- INT is registered: INT = |(INT_PEND & INT_EN) from the previous cycle, so one cycle of latency after a pending bit or enable changes.
- Reset:
  - FSM=IDLE; wait counter, CONFIG, TIMEOUT, INT_EN, INT_PEND, wait_timeout_seen and INT are 0.
  - Reset asserted mid-wait aborts the transfer with no strobe.
- Reading INT_PEND does not clear it.

Test Plan:
1. Write CONFIG with PWDATA=0xFFFF_FFFF, then read it -> PRDATA=0x0000_3FFF; both transfers zero-wait with PSLVERR=0.
2. TXDATA write 0xA5 with TX_FULL=1 for 3 ACCESS cycles then 0 -> PREADY=0 for 3 cycles; in the 4th, PREADY=1, WR_ENA pulses once, WRITE_DATA_ON_TX=0xA5.
3. RXDATA read with RX_EMPTY held 1, WAIT_MAX=16 -> PREADY=1 and PSLVERR=1 in ACCESS cycle 16, RD_ENA never asserts, STATUS[4]=1, INT_PEND=0x8.
4. INT_EN=0x4, pulse I2C_ERROR -> INT_PEND[2]=1, INT=1 one cycle later; write INT_PEND=0x4 -> INT_PEND=0 and INT falls one cycle later. Repeat with the error edge coinciding with the W1C write -> bit stays 1.
5. Read offset 0x1C and write STATUS -> zero-wait PSLVERR=1, and no register changes.
6. Assert PRESET during a TX_FULL wait -> no WR_ENA, FSM returns to IDLE; CONFIG, TIMEOUT and INT read 0 after release.
